// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I decode/issue register in front of the 4-bit-opcode ALU.
// Decodes one instruction into ALU opcode plus operands, with one level of
// writeback forwarding. The decoded entry is held behind a valid/ready
// handshake, so alu_op/alu_x/alu_y stay stable while execute stalls.

// Operand source select: takes the writeback value when it targets this
// source register (never for x0), otherwise the register-file read.
module alu_issue_fwd #(
  parameter int XLEN = 32
) (
  input  logic [4:0]      src,
  input  logic [XLEN-1:0] rf_data,
  input  logic            fwd_we,
  input  logic [4:0]      fwd_rd,
  input  logic [XLEN-1:0] fwd_data,
  output logic [XLEN-1:0] value
);
  logic hit;

  assign hit   = fwd_we && (fwd_rd != 5'd0) && (fwd_rd == src);
  assign value = hit ? fwd_data : rf_data;
endmodule

module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            fwd_we,
  input  logic [4:0]      fwd_rd,
  input  logic [XLEN-1:0] fwd_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_x,
  output logic [XLEN-1:0] alu_y,
  output logic [4:0]      rd,
  output logic            rd_we,
  output logic            is_branch,
  output logic [XLEN-1:0] branch_target,
  output logic            unsupported
);

  // ALU opcode encoding
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_MUL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0111;
  localparam logic [3:0] OP_EQ  = 4'b1000;
  localparam logic [3:0] OP_NE  = 4'b1001;
  localparam logic [3:0] OP_LT  = 4'b1010;
  localparam logic [3:0] OP_GE  = 4'b1011;

  // RV32I major opcodes handled here
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [3:0]      op;
    logic [XLEN-1:0] x;
    logic [XLEN-1:0] y;
    logic [4:0]      rd;
    logic            rd_we;
    logic            br;
    logic [XLEN-1:0] tgt;
    logic            unsup;
  } issue_t;

  // instruction fields
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd_f;

  assign opcode = instr[6:0];
  assign rd_f   = instr[11:7];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // forwarded source operands, index 0 = rs1, 1 = rs2
  logic [1:0][4:0]      src;
  logic [1:0][XLEN-1:0] rf_rd;
  logic [1:0][XLEN-1:0] opv;

  assign src[0]   = instr[19:15];
  assign src[1]   = instr[24:20];
  assign rf_rd[0] = rs1_data;
  assign rf_rd[1] = rs2_data;

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    alu_issue_fwd #(.XLEN(XLEN)) u_fwd (
      .src      (src[g]),
      .rf_data  (rf_rd[g]),
      .fwd_we   (fwd_we),
      .fwd_rd   (fwd_rd),
      .fwd_data (fwd_data),
      .value    (opv[g])
    );
  end

  // immediates
  logic [XLEN-1:0] imm_i, imm_b, imm_u, sh_reg, sh_imm;

  assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_b  = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign sh_reg = {{(XLEN-5){1'b0}}, opv[1][4:0]};
  assign sh_imm = {{(XLEN-5){1'b0}}, instr[24:20]};

  // decode the incoming instruction into the entry that an accept would load
  issue_t dec;
  logic   ok;
  logic   writes_rd;

  always_comb begin
    dec       = '0;
    ok        = 1'b0;
    writes_rd = 1'b0;
    case (opcode)
      OPC_OP: begin
        ok        = 1'b1;
        writes_rd = 1'b1;
        dec.x     = opv[0];
        dec.y     = opv[1];
        case ({funct7, funct3})
          {7'b0000000, 3'b000}: dec.op = OP_ADD;
          {7'b0000000, 3'b001}: begin dec.op = OP_SLL; dec.y = sh_reg; end
          {7'b0000000, 3'b010}: dec.op = OP_LT;
          {7'b0000000, 3'b100}: dec.op = OP_XOR;
          {7'b0000000, 3'b101}: begin dec.op = OP_SRL; dec.y = sh_reg; end
          {7'b0000000, 3'b110}: dec.op = OP_OR;
          {7'b0000000, 3'b111}: dec.op = OP_AND;
          {7'b0100000, 3'b000}: dec.op = OP_SUB;
          {7'b0000001, 3'b000}: dec.op = OP_MUL;
          default:              ok     = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        ok        = 1'b1;
        writes_rd = 1'b1;
        dec.x     = opv[0];
        dec.y     = imm_i;
        case (funct3)
          3'b000: dec.op = OP_ADD;
          3'b010: dec.op = OP_LT;
          3'b100: dec.op = OP_XOR;
          3'b110: dec.op = OP_OR;
          3'b111: dec.op = OP_AND;
          3'b001: begin dec.op = OP_SLL; dec.y = sh_imm; ok = (funct7 == 7'b0); end
          3'b101: begin dec.op = OP_SRL; dec.y = sh_imm; ok = (funct7 == 7'b0); end
          default: ok = 1'b0;
        endcase
      end
      OPC_BRANCH: begin
        ok      = 1'b1;
        dec.x   = opv[0];
        dec.y   = opv[1];
        dec.br  = 1'b1;
        dec.tgt = pc + imm_b;
        case (funct3)
          3'b000:  dec.op = OP_EQ;
          3'b001:  dec.op = OP_NE;
          3'b100:  dec.op = OP_LT;
          3'b101:  dec.op = OP_GE;
          default: ok     = 1'b0;
        endcase
      end
      OPC_LUI: begin
        ok        = 1'b1;
        writes_rd = 1'b1;
        dec.op    = OP_ADD;
        dec.y     = imm_u;
      end
      OPC_AUIPC: begin
        ok        = 1'b1;
        writes_rd = 1'b1;
        dec.op    = OP_ADD;
        dec.x     = pc;
        dec.y     = imm_u;
      end
      default: ok = 1'b0;
    endcase

    if (ok) begin
      dec.rd    = writes_rd ? rd_f : 5'd0;
      dec.rd_we = writes_rd && (rd_f != 5'd0);
    end else begin
      // anything not handled is still issued, as an inert marked entry
      dec       = '0;
      dec.unsup = 1'b1;
    end
  end

  // handshake
  logic   vld;
  logic   accept;
  issue_t q;

  assign in_ready = !vld || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // hold register: flush wins, then accept, then drain on consume
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0;
      q   <= '0;
    end else if (flush) begin
      vld <= 1'b0;
    end else if (accept) begin
      vld <= 1'b1;
      q   <= dec;
    end else if (out_ready) begin
      vld <= 1'b0;
    end
  end

  assign out_valid     = vld;
  assign alu_op        = q.op;
  assign alu_x         = q.x;
  assign alu_y         = q.y;
  assign rd            = q.rd;
  assign rd_we         = q.rd_we;
  assign is_branch     = q.br;
  assign branch_target = q.tgt;
  assign unsupported   = q.unsup;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios, then randomized traffic
// checked against an encoder-side reference model (each random instruction is
// built from a mnemonic, and the expected ALU entry follows from the mnemonic).
module tb_alu_issue_stage;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, fwd_we, out_valid, out_ready;
  logic [31:0] instr, pc, rs1_data, rs2_data, fwd_data, alu_x, alu_y, branch_target;
  logic [4:0]  fwd_rd, rd;
  logic [3:0]  alu_op;
  logic        rd_we, is_branch, unsupported;

  alu_issue_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .fwd_we(fwd_we), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op), .alu_x(alu_x),
    .alu_y(alu_y), .rd(rd), .rd_we(rd_we), .is_branch(is_branch),
    .branch_target(branch_target), .unsupported(unsupported)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  rd;
    logic        rd_we;
    logic        br;
    logic [31:0] tgt;
    logic        unsup;
  } exp_t;

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2, s1,
                                        input logic [2:0] f3, input logic [4:0] d, input logic [6:0] opc);
    return {f7, s2, s1, f3, d, opc};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] s1,
                                        input logic [2:0] f3, input logic [4:0] d, input logic [6:0] opc);
    return {im, s1, f3, d, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] s2, s1);
    return {im[11:5], s2, s1, 3'b010, im[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input int off, input logic [4:0] s2, s1, input logic [2:0] f3);
    logic [12:0] o;
    o = 13'(off);
    return {o[12], o[10:5], s2, s1, f3, o[4:1], o[11], 7'b1100011};
  endfunction

  // ---------------- expectation builders ----------------
  function automatic exp_t mk(input logic [3:0] op, input logic [31:0] x, y, input logic [4:0] d);
    exp_t r = '0;
    r.op = op; r.x = x; r.y = y; r.rd = d; r.rd_we = (d != 5'd0);
    return r;
  endfunction

  function automatic exp_t mkb(input logic [3:0] op, input logic [31:0] x, y, tgt);
    exp_t r = '0;
    r.op = op; r.x = x; r.y = y; r.br = 1'b1; r.tgt = tgt;
    return r;
  endfunction

  function automatic exp_t bad();
    exp_t r = '0;
    r.unsup = 1'b1;
    return r;
  endfunction

  task automatic drv(input logic iv, input logic [31:0] ins, p, a, b, input logic fwe,
                     input logic [4:0] frd, input logic [31:0] fd, input logic ordy, fl);
    in_valid = iv; instr = ins; pc = p; rs1_data = a; rs2_data = b;
    fwd_we = fwe; fwd_rd = frd; fwd_data = fd; out_ready = ordy; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random instruction + operands; drives the DUT inputs and returns what an
  // accept this cycle should load.
  task automatic rand_cycle(output exp_t e);
    logic [4:0]  d, s1, s2;
    logic [31:0] a, b, p, v1, v2, ins;
    logic [19:0] up;
    int          m, imm, boff, sh;
    d = 5'($urandom); s1 = 5'($urandom); s2 = 5'($urandom);
    a = $urandom; b = $urandom; p = $urandom & 32'hFFFF_FFFC;
    up = 20'($urandom);
    imm  = int'($urandom_range(0, 4095)) - 2048;
    boff = (int'($urandom_range(0, 4095)) - 2048) * 2;
    sh   = int'($urandom_range(0, 31));
    fwd_we   = 1'($urandom_range(0, 1));
    fwd_data = $urandom;
    case ($urandom_range(0, 3))
      0:       fwd_rd = s1;
      1:       fwd_rd = s2;
      2:       fwd_rd = 5'd0;
      default: fwd_rd = 5'($urandom);
    endcase
    v1 = (fwd_we && fwd_rd != 0 && fwd_rd == s1) ? fwd_data : a;
    v2 = (fwd_we && fwd_rd != 0 && fwd_rd == s2) ? fwd_data : b;
    m = int'($urandom_range(0, 36));
    case (m)
      0:  begin ins = enc_r(7'h00, s2, s1, 3'd0, d, 7'h33); e = mk(4'h3, v1, v2, d); end
      1:  begin ins = enc_r(7'h20, s2, s1, 3'd0, d, 7'h33); e = mk(4'h4, v1, v2, d); end
      2:  begin ins = enc_r(7'h00, s2, s1, 3'd1, d, 7'h33); e = mk(4'h7, v1, v2 % 32, d); end
      3:  begin ins = enc_r(7'h00, s2, s1, 3'd2, d, 7'h33); e = mk(4'hA, v1, v2, d); end
      4:  begin ins = enc_r(7'h00, s2, s1, 3'd4, d, 7'h33); e = mk(4'h2, v1, v2, d); end
      5:  begin ins = enc_r(7'h00, s2, s1, 3'd5, d, 7'h33); e = mk(4'h6, v1, v2 % 32, d); end
      6:  begin ins = enc_r(7'h00, s2, s1, 3'd6, d, 7'h33); e = mk(4'h1, v1, v2, d); end
      7:  begin ins = enc_r(7'h00, s2, s1, 3'd7, d, 7'h33); e = mk(4'h0, v1, v2, d); end
      8:  begin ins = enc_r(7'h01, s2, s1, 3'd0, d, 7'h33); e = mk(4'h5, v1, v2, d); end
      9:  begin ins = enc_i(12'(imm), s1, 3'd0, d, 7'h13); e = mk(4'h3, v1, 32'(imm), d); end
      10: begin ins = enc_i(12'(imm), s1, 3'd2, d, 7'h13); e = mk(4'hA, v1, 32'(imm), d); end
      11: begin ins = enc_i(12'(imm), s1, 3'd4, d, 7'h13); e = mk(4'h2, v1, 32'(imm), d); end
      12: begin ins = enc_i(12'(imm), s1, 3'd6, d, 7'h13); e = mk(4'h1, v1, 32'(imm), d); end
      13: begin ins = enc_i(12'(imm), s1, 3'd7, d, 7'h13); e = mk(4'h0, v1, 32'(imm), d); end
      14: begin ins = enc_i({7'h00, 5'(sh)}, s1, 3'd1, d, 7'h13); e = mk(4'h7, v1, 32'(sh), d); end
      15: begin ins = enc_i({7'h00, 5'(sh)}, s1, 3'd5, d, 7'h13); e = mk(4'h6, v1, 32'(sh), d); end
      16: begin ins = enc_b(boff, s2, s1, 3'd0); e = mkb(4'h8, v1, v2, p + 32'(boff)); end
      17: begin ins = enc_b(boff, s2, s1, 3'd1); e = mkb(4'h9, v1, v2, p + 32'(boff)); end
      18: begin ins = enc_b(boff, s2, s1, 3'd4); e = mkb(4'hA, v1, v2, p + 32'(boff)); end
      19: begin ins = enc_b(boff, s2, s1, 3'd5); e = mkb(4'hB, v1, v2, p + 32'(boff)); end
      20: begin ins = {up, d, 7'h37}; e = mk(4'h3, 32'd0, {up, 12'h000}, d); end
      21: begin ins = {up, d, 7'h17}; e = mk(4'h3, p, {up, 12'h000}, d); end
      22: begin ins = enc_r(7'h20, s2, s1, 3'd5, d, 7'h33); e = bad(); end
      23: begin ins = enc_i({7'h20, 5'(sh)}, s1, 3'd5, d, 7'h13); e = bad(); end
      24: begin ins = enc_r(7'h00, s2, s1, 3'd3, d, 7'h33); e = bad(); end
      25: begin ins = enc_i(12'(imm), s1, 3'd3, d, 7'h13); e = bad(); end
      26: begin ins = enc_b(boff, s2, s1, 3'd6); e = bad(); end
      27: begin ins = enc_b(boff, s2, s1, 3'd7); e = bad(); end
      28: begin ins = enc_r(7'h01, s2, s1, 3'd1, d, 7'h33); e = bad(); end
      29: begin ins = enc_i(12'(imm), s1, 3'd2, d, 7'h03); e = bad(); end
      30: begin ins = enc_s(12'(imm), s2, s1); e = bad(); end
      31: begin ins = {up, d, 7'h6F}; e = bad(); end
      32: begin ins = enc_i(12'(imm), s1, 3'd0, d, 7'h67); e = bad(); end
      33: begin ins = 32'h0000_0073; e = bad(); end
      34: begin ins = 32'h0FF0_000F; e = bad(); end
      35: begin ins = enc_i({7'h01, 5'(sh)}, s1, 3'd1, d, 7'h13); e = bad(); end
      default: begin ins = enc_b(boff, s2, s1, 3'd2); e = bad(); end
    endcase
    instr = ins; pc = p; rs1_data = a; rs2_data = b;
    in_valid  = ($urandom_range(0, 3) != 0);
    out_ready = ($urandom_range(0, 4) < 3);
    flush     = ($urandom_range(0, 11) == 0);
  endtask

  exp_t mq, e_in;
  bit   mv;

  task automatic chk_held(input string p);
    chk({p, "_valid"}, 32'(out_valid), 32'(mv));
    if (mv) begin
      chk({p, "_op"},    32'(alu_op),        32'(mq.op));
      chk({p, "_x"},     alu_x,              mq.x);
      chk({p, "_y"},     alu_y,              mq.y);
      chk({p, "_rdwe"},  32'(rd_we),         32'(mq.rd_we));
      chk({p, "_br"},    32'(is_branch),     32'(mq.br));
      chk({p, "_tgt"},   branch_target,      mq.tgt);
      chk({p, "_unsup"}, 32'(unsupported),   32'(mq.unsup));
      if (!mq.unsup) chk({p, "_rd"}, 32'(rd), 32'(mq.rd));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drv(0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
    #12;
    // reset state
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_op",    32'(alu_op), 0);
    chk("rst_x",     alu_x, 0);
    chk("rst_y",     alu_y, 0);
    chk("rst_rd",    32'(rd), 0);
    chk("rst_rdwe",  32'(rd_we), 0);
    chk("rst_br",    32'(is_branch), 0);
    chk("rst_tgt",   branch_target, 0);
    chk("rst_unsup", 32'(unsupported), 0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // addi x5,x1,-3
    drv(1, 32'hFFD0_8293, 32'h0, 32'd10, 32'd0, 0, 5'd0, 32'h0, 1, 0);
    tick();
    chk("addi_valid", 32'(out_valid), 1);
    chk("addi_op", 32'(alu_op), 32'h3);
    chk("addi_x", alu_x, 32'd10);
    chk("addi_y", alu_y, 32'hFFFF_FFFD);
    chk("addi_rd", 32'(rd), 5);
    chk("addi_rdwe", 32'(rd_we), 1);

    // add x3,x1,x2 with rs1 forwarded
    drv(1, 32'h0020_81B3, 32'h0, 32'd1, 32'd2, 1, 5'd1, 32'h55, 1, 0);
    tick();
    chk("fwd_x", alu_x, 32'h55);
    chk("fwd_y", alu_y, 32'd2);
    // add x3,x0,x2 with fwd_rd=0: x0 never forwarded
    drv(1, 32'h0020_01B3, 32'h0, 32'd7, 32'd2, 1, 5'd0, 32'h55, 1, 0);
    tick();
    chk("fwd_x0", alu_x, 32'd7);

    // bge x1,x2,+16 at 0x100
    drv(1, 32'h0020_D863, 32'h100, 32'd4, 32'd9, 0, 5'd0, 32'h0, 1, 0);
    tick();
    chk("bge_op", 32'(alu_op), 32'hB);
    chk("bge_br", 32'(is_branch), 1);
    chk("bge_rdwe", 32'(rd_we), 0);
    chk("bge_tgt", branch_target, 32'h110);
    // bltu
    drv(1, 32'h0020_E863, 32'h100, 32'd4, 32'd9, 0, 5'd0, 32'h0, 1, 0);
    tick();
    chk("bltu_unsup", 32'(unsupported), 1);
    chk("bltu_op", 32'(alu_op), 0);
    chk("bltu_br", 32'(is_branch), 0);

    // backpressure: load addi, then stall 3 cycles with new input pending
    drv(1, 32'hFFD0_8293, 32'h0, 32'd10, 32'd0, 0, 5'd0, 32'h0, 1, 0);
    tick();
    drv(1, 32'h0020_81B3, 32'h0, 32'd1, 32'd2, 0, 5'd0, 32'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 0);
      tick();
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_op", 32'(alu_op), 32'h3);
      chk("bp_x", alu_x, 32'd10);
      chk("bp_y", alu_y, 32'hFFFF_FFFD);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 1);
    tick();
    chk("bp_next_valid", 32'(out_valid), 1);
    chk("bp_next_x", alu_x, 32'd1);
    chk("bp_next_y", alu_y, 32'd2);
    chk("bp_next_rd", 32'(rd), 3);

    // flush with a pending accept: entry dropped, data untouched
    drv(1, 32'hFFD0_8293, 32'h0, 32'd10, 32'd0, 0, 5'd0, 32'h0, 1, 1);
    tick();
    chk("flush_valid", 32'(out_valid), 0);
    drv(0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 1, 0);
    tick();
    chk("flush_lost", 32'(out_valid), 0);
    chk("flush_x_held", alu_x, 32'd1);

    // asynchronous reset mid-stream
    drv(1, 32'h0020_81B3, 32'h0, 32'd1, 32'd2, 0, 5'd0, 32'h0, 0, 0);
    tick();
    chk("pre_rst_valid", 32'(out_valid), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_op", 32'(alu_op), 0);
    chk("async_rst_x", alu_x, 0);
    #2 rst_n = 1'b1;
    drv(0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 1, 0);
    tick();

    // randomized traffic against the model
    mv = 1'b0;
    mq = '0;
    for (int c = 0; c < 600; c++) begin
      rand_cycle(e_in);
      #1;
      chk("rnd_in_ready", 32'(in_ready), 32'(!mv || out_ready));
      if (flush) mv = 1'b0;
      else if (in_valid && (!mv || out_ready)) begin mv = 1'b1; mq = e_in; end
      else if (out_ready) mv = 1'b0;
      tick();
      chk_held("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
